// File: rtl/mult_err_sweep_ctrl.sv
// Self-characterisation engine for an external approximate NxN multiplier.
// Sweeps every operand pair, collects the returned products and accumulates error statistics.
module mult_err_sweep_ctrl #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  output logic             op_valid,
  input  logic [2*N-1:0]   prod_in,
  input  logic             prod_valid,
  output logic [2*N:0]     total_count,
  output logic [2*N:0]     nonzero_count,
  output logic [2*N:0]     err_count,
  output logic [4*N-1:0]   sum_ed,
  output logic [6*N-1:0]   sum_sq_ed,
  output logic [2*N-1:0]   max_ed
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_DONE} state_t;

  localparam logic [N-1:0] IDX_MAX  = '1;
  localparam logic [15:0]  TMO_LOAD = 16'(TIMEOUT);
  localparam logic [2*N:0] CNT_ONE  = (2*N+1)'(1);

  state_t         state, state_nxt;
  logic [N-1:0]   a_idx, b_idx, a_nxt, b_nxt;
  logic [15:0]    tmo_cnt;
  logic [2*N-1:0] prod_q, exact, ed;
  logic [4*N-1:0] ed_sq;
  logic           last_pair;

  // Exact reference and error distance for the pair currently held in the indices.
  always_comb begin
    exact     = {{N{1'b0}}, a_idx} * {{N{1'b0}}, b_idx};
    ed        = (prod_q >= exact) ? (prod_q - exact) : (exact - prod_q);
    ed_sq     = {{2*N{1'b0}}, ed} * {{2*N{1'b0}}, ed};
    last_pair = (a_idx == IDX_MAX) && (b_idx == IDX_MAX);
    a_nxt     = (b_idx == IDX_MAX) ? a_idx + 1'b1 : a_idx;
    b_nxt     = (b_idx == IDX_MAX) ? '0 : b_idx + 1'b1;
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_ISSUE;
      S_ISSUE:        state_nxt = S_WAIT;
      S_WAIT: begin
        if (prod_valid)         state_nxt = S_ACCUM;
        else if (tmo_cnt <= 16'd1) state_nxt = S_DONE;
      end
      S_ACCUM:        state_nxt = last_pair ? S_DONE : S_ISSUE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_ACCUM);
  assign done     = (state == S_DONE);
  assign op_valid = (state == S_ISSUE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_idx         <= '0;
      b_idx         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      tmo_cnt       <= '0;
      prod_q        <= '0;
      timeout_err   <= 1'b0;
      total_count   <= '0;
      nonzero_count <= '0;
      err_count     <= '0;
      sum_ed        <= '0;
      sum_sq_ed     <= '0;
      max_ed        <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_idx         <= '0;
            b_idx         <= '0;
            op_a          <= '0;
            op_b          <= '0;
            timeout_err   <= 1'b0;
            total_count   <= '0;
            nonzero_count <= '0;
            err_count     <= '0;
            sum_ed        <= '0;
            sum_sq_ed     <= '0;
            max_ed        <= '0;
          end
        end
        S_ISSUE: tmo_cnt <= TMO_LOAD;
        S_WAIT: begin
          if (prod_valid) begin
            prod_q <= prod_in;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
            if (tmo_cnt <= 16'd1) timeout_err <= 1'b1;
          end
        end
        S_ACCUM: begin
          total_count   <= total_count + CNT_ONE;
          nonzero_count <= nonzero_count + ((exact != '0) ? CNT_ONE : '0);
          err_count     <= err_count + ((ed != '0) ? CNT_ONE : '0);
          sum_ed        <= sum_ed + {{2*N{1'b0}}, ed};
          sum_sq_ed     <= sum_sq_ed + {{2*N{1'b0}}, ed_sq};
          if (ed > max_ed) max_ed <= ed;
          a_idx <= a_nxt;
          b_idx <= b_nxt;
          // Operands only move when another pair will be issued, so they hold through DONE.
          if (!last_pair) begin
            op_a <= a_nxt;
            op_b <= b_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Bench for mult_err_sweep_ctrl: a behavioural multiplier responder, table-driven sweep results
// and hand-written sequences for timeout, start-while-busy and asynchronous reset.
module tb_mult_err_sweep_ctrl;

  localparam int N   = 4;
  localparam int TMO = 10;
  localparam int SZ  = 1 << N;

  typedef enum int {M_EXACT, M_ZERO, M_PLUS1, M_NONE, M_RAND_LAT, M_RAND_ERR} mode_t;

  typedef struct {
    mode_t  mode;
    bit     poke_start;
    longint total, nz, err, sed, ssq, maxed;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done, timeout_err, op_valid;
  logic [N-1:0]     op_a, op_b;
  logic [2*N-1:0]   prod_in;
  logic             prod_valid;
  logic [2*N:0]     total_count, nonzero_count, err_count;
  logic [4*N-1:0]   sum_ed;
  logic [6*N-1:0]   sum_sq_ed;
  logic [2*N-1:0]   max_ed;

  mult_err_sweep_ctrl #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .prod_in(prod_in), .prod_valid(prod_valid), .total_count(total_count),
    .nonzero_count(nonzero_count), .err_count(err_count), .sum_ed(sum_ed),
    .sum_sq_ed(sum_sq_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  mode_t       mode     = M_EXACT;
  logic [7:0]  issued[$];
  int          resp_tab[SZ][SZ];
  vec_t        vecs[5];

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Product the behavioural multiplier returns for a pair in a given mode.
  function automatic int resp_of(input mode_t m, input int a, input int b);
    case (m)
      M_ZERO:     return 0;
      M_PLUS1:    return (a * b + 1) % (SZ * SZ);
      M_RAND_ERR: return resp_tab[a][b];
      default:    return a * b;
    endcase
  endfunction

  // Statistics expected from a complete sweep, straight from the definitions.
  task automatic model(input mode_t m, output vec_t v);
    v.mode = m; v.poke_start = 1'b0;
    v.total = 0; v.nz = 0; v.err = 0; v.sed = 0; v.ssq = 0; v.maxed = 0;
    for (int a = 0; a < SZ; a++) begin
      for (int b = 0; b < SZ; b++) begin
        longint ex, ed;
        ex = a * b;
        ed = resp_of(m, a, b) - ex;
        if (ed < 0) ed = -ed;
        v.total++;
        if (ex != 0) v.nz++;
        if (ed != 0) v.err++;
        v.sed += ed;
        v.ssq += ed * ed;
        if (ed > v.maxed) v.maxed = ed;
      end
    end
  endtask

  // Behavioural multiplier: sees each issue at the falling edge and answers after a latency.
  initial begin
    bit pend;
    int wait_n;
    int resp;
    prod_valid = 1'b0;
    prod_in    = '0;
    pend       = 1'b0;
    wait_n     = 0;
    resp       = 0;
    forever begin
      @(negedge clk);
      prod_valid = 1'b0;
      prod_in    = '0;
      if (rst) pend = 1'b0;
      if (pend) begin
        if (wait_n == 0) begin
          prod_valid = 1'b1;
          prod_in    = 8'(resp);
          pend       = 1'b0;
        end else begin
          wait_n--;
        end
      end
      if (op_valid && !rst) begin
        issued.push_back({op_a, op_b});
        resp   = resp_of(mode, int'(op_a), int'(op_b));
        pend   = (mode != M_NONE);
        wait_n = (mode == M_RAND_LAT || mode == M_RAND_ERR) ? int'($urandom_range(0, 5)) : 0;
        if (mode == M_RAND_LAT && $urandom_range(0, 3) == 0) begin
          prod_valid = 1'b1;
          prod_in    = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_op_valid"}, op_valid, 0);
    check({tag, "_op_a"}, op_a, 0);
    check({tag, "_op_b"}, op_b, 0);
    check({tag, "_total_count"}, total_count, 0);
    check({tag, "_nonzero_count"}, nonzero_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_sum_ed"}, sum_ed, 0);
    check({tag, "_sum_sq_ed"}, sum_sq_ed, 0);
    check({tag, "_max_ed"}, max_ed, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_row(input int i);
    int cycles;
    int bad;
    string tag;
    tag = $sformatf("row%0d", i);
    mode = vecs[i].mode;
    issued.delete();
    pulse_start();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_done_cleared"}, done, 0);
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      start = (vecs[i].poke_start && cycles == 50);
    end
    start = 1'b0;
    check({tag, "_finished"}, done, 1);
    check({tag, "_busy_at_end"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_total_count"}, total_count, vecs[i].total);
    check({tag, "_nonzero_count"}, nonzero_count, vecs[i].nz);
    check({tag, "_err_count"}, err_count, vecs[i].err);
    check({tag, "_sum_ed"}, sum_ed, vecs[i].sed);
    check({tag, "_sum_sq_ed"}, sum_sq_ed, vecs[i].ssq);
    check({tag, "_max_ed"}, max_ed, vecs[i].maxed);
    check({tag, "_issue_count"}, issued.size(), SZ * SZ);
    bad = 0;
    foreach (issued[k]) if (issued[k] != 8'(k)) bad++;
    check({tag, "_issue_order_mismatches"}, bad, 0);
    if (vecs[i].mode == M_EXACT) check({tag, "_sweep_cycles"}, cycles, 3 * SZ * SZ);
  endtask

  initial begin
    int waits;
    vec_t v;
    rst   = 1'b1;
    start = 1'b0;

    for (int a = 0; a < SZ; a++)
      for (int b = 0; b < SZ; b++)
        resp_tab[a][b] = ($urandom_range(0, 2) == 0) ? a * b : int'($urandom_range(0, SZ * SZ - 1));

    vecs[0] = '{mode: M_EXACT,    poke_start: 1'b0, total: 256, nz: 225, err: 0,   sed: 0,     ssq: 0,       maxed: 0};
    vecs[1] = '{mode: M_ZERO,     poke_start: 1'b0, total: 256, nz: 225, err: 225, sed: 14400, ssq: 1537600, maxed: 225};
    vecs[2] = '{mode: M_PLUS1,    poke_start: 1'b0, total: 256, nz: 225, err: 256, sed: 256,   ssq: 256,     maxed: 1};
    vecs[3] = '{mode: M_RAND_LAT, poke_start: 1'b1, total: 256, nz: 225, err: 0,   sed: 0,     ssq: 0,       maxed: 0};
    model(M_RAND_ERR, v);
    vecs[4] = v;

    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) run_row(i);

    // No response ever: abort after exactly TMO wait cycles with partial (empty) statistics.
    mode = M_NONE;
    pulse_start();
    check("tmo_op_valid_first_cycle", op_valid, 1);
    waits = 0;
    @(negedge clk);
    while (!done && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check("tmo_wait_cycles", waits, TMO);
    check("tmo_done", done, 1);
    check("tmo_timeout_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_total_count", total_count, 0);

    for (int i = 3; i < 5; i++) run_row(i);

    // Asynchronous reset in the middle of a sweep.
    mode = M_EXACT;
    issued.delete();
    pulse_start();
    waits = 0;
    while (issued.size() < 100 && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    check("midrst_reached_100_pairs", (issued.size() >= 100), 1);
    #2 rst = 1'b1;
    #1 outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_row(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
